// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel 3x3 window address generator.
//   state_e           : scan FSM states (IDLE/SCAN/DONE)
//   TAP_LAST          : index of the final (bottom-right) kernel tap
//   TAP_DR1 / TAP_DC1 : per-tap row/col offset biased by +1 (0 => -1, 1 => 0, 2 => +1)
//   COORD_W_DEF / ADDR_W_DEF : default coordinate and address widths
package sobel_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;

  localparam logic [3:0] TAP_LAST    = 4'd8;
  localparam int         COORD_W_DEF = 8;
  localparam int         ADDR_W_DEF  = 16;

  // Offsets are stored with a +1 bias so all arithmetic stays unsigned.
  localparam logic [8:0][1:0] TAP_DR1 =
    {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic [8:0][1:0] TAP_DC1 =
    {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
endpackage

// File: rtl/sobel_tap_addr.sv
// Combinational (center row, center col, tap) -> linear read address.
// With BORDER_REPLICATE_EN defined, tap coordinates are clamped to the image
// (edge replication); otherwise the center is always interior and no clamp exists.
// Ports:
//   row_i, col_i : center pixel coordinates
//   tap_i        : kernel tap 0..8, row-major
//   addr_o       : tap_row*IMG_W + tap_col
module sobel_tap_addr
  import sobel_pkg::*;
#(
  parameter int IMG_W   = 256,
`ifdef BORDER_REPLICATE_EN
  parameter int IMG_H   = 256,
`endif
  parameter int COORD_W = COORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic [COORD_W-1:0] row_i,
  input  logic [COORD_W-1:0] col_i,
  input  logic [3:0]         tap_i,
  output logic [ADDR_W-1:0]  addr_o
);
  localparam int CW1 = COORD_W + 1;

  logic [CW1-1:0] r1, c1, tap_row, tap_col;

  // r1/c1 = coord + offset + 1: never negative, one spare bit so no wrap.
  assign r1 = {1'b0, row_i} + CW1'(TAP_DR1[tap_i]);
  assign c1 = {1'b0, col_i} + CW1'(TAP_DC1[tap_i]);

`ifdef BORDER_REPLICATE_EN
  // r1==0 means coordinate -1; r1 > dim means coordinate == dim.
  assign tap_row = (r1 == '0) ? '0 :
                   (r1 > CW1'(IMG_H)) ? CW1'(IMG_H - 1) : r1 - CW1'(1);
  assign tap_col = (c1 == '0) ? '0 :
                   (c1 > CW1'(IMG_W)) ? CW1'(IMG_W - 1) : c1 - CW1'(1);
`else
  assign tap_row = r1 - CW1'(1);
  assign tap_col = c1 - CW1'(1);
`endif

  assign addr_o = ADDR_W'(tap_row) * ADDR_W'(IMG_W) + ADDR_W'(tap_col);
endmodule

// File: rtl/sobel_window_addr_gen.sv
// Raster-order 3x3 window read-address generator for the Sobel datapath.
// On In_Start (IDLE only) it walks every center pixel and emits its 9 tap
// addresses over a valid/ready handshake, then pulses Out_Frame_Done.
// Optional macro BORDER_REPLICATE_EN: scan every pixel with clamped taps;
// undefined: scan interior pixels only.
// Ports:
//   Clk, Rst_n        : clock, synchronous active-low reset
//   In_Start          : frame start pulse (honoured in IDLE only)
//   In_Ready          : read port accepts current address
//   Out_Valid         : address/tap/center outputs valid
//   Out_Addr, Out_Tap : linear tap address, tap index 0..8
//   Out_Row_Value, Out_Column_Value : center pixel coordinates
//   Out_Last_Tap      : tap 8 of the window
//   Out_Frame_Done    : one-cycle pulse after the final handshake
//   Out_Busy          : scanning
module sobel_window_addr_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int COORD_W = COORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               In_Start,
  input  logic               In_Ready,
  output logic               Out_Valid,
  output logic [ADDR_W-1:0]  Out_Addr,
  output logic [3:0]         Out_Tap,
  output logic [COORD_W-1:0] Out_Row_Value,
  output logic [COORD_W-1:0] Out_Column_Value,
  output logic               Out_Last_Tap,
  output logic               Out_Frame_Done,
  output logic               Out_Busy
);
`ifdef BORDER_REPLICATE_EN
  localparam logic [COORD_W-1:0] R0    = '0;
  localparam logic [COORD_W-1:0] R_MAX = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] C0    = '0;
  localparam logic [COORD_W-1:0] C_MAX = COORD_W'(IMG_W - 1);
`else
  localparam logic [COORD_W-1:0] R0    = COORD_W'(1);
  localparam logic [COORD_W-1:0] R_MAX = COORD_W'(IMG_H - 2);
  localparam logic [COORD_W-1:0] C0    = COORD_W'(1);
  localparam logic [COORD_W-1:0] C_MAX = COORD_W'(IMG_W - 2);
`endif

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   row_q, row_d, col_q, col_d;
  logic [3:0]           tap_q, tap_d;
  logic                 valid_q, valid_d, last_q;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 hs;

  assign hs = valid_q & In_Ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tap_d   = tap_q;
    unique case (state_q)
      IDLE: if (In_Start) begin
        state_d = SCAN;
        row_d   = R0;
        col_d   = C0;
        tap_d   = '0;
      end
      SCAN: if (hs) begin
        if (tap_q != TAP_LAST) begin
          tap_d = tap_q + 4'd1;
        end else begin
          tap_d = '0;
          if (col_q != C_MAX) begin
            col_d = col_q + COORD_W'(1);
          end else if (row_q != R_MAX) begin
            col_d = C0;
            row_d = row_q + COORD_W'(1);
          end else begin
            // Final window accepted: counters park at zero for IDLE.
            state_d = DONE;
            row_d   = '0;
            col_d   = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == SCAN);
  end

  // Address is computed from next-state counters so it registers alongside them.
  sobel_tap_addr #(
    .IMG_W   (IMG_W),
`ifdef BORDER_REPLICATE_EN
    .IMG_H   (IMG_H),
`endif
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W)
  ) u_tap_addr (
    .row_i  (row_d),
    .col_i  (col_d),
    .tap_i  (tap_d),
    .addr_o (addr_d)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      tap_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tap_q   <= tap_d;
      valid_q <= valid_d;
      addr_q  <= valid_d ? addr_d : '0;
      last_q  <= valid_d && (tap_d == TAP_LAST);
    end
  end

  assign Out_Valid        = valid_q;
  assign Out_Addr         = addr_q;
  assign Out_Tap          = tap_q;
  assign Out_Row_Value    = row_q;
  assign Out_Column_Value = col_q;
  assign Out_Last_Tap     = last_q;
  assign Out_Frame_Done   = (state_q == DONE);
  assign Out_Busy         = (state_q == SCAN);
endmodule
